mips_muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the MIPS CPU datapath.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Fed from register-file read data (rs, rt). Its hi/lo outputs feed the MFHI/MFLO path of the MemtoReg mux.
- Uses a start/busy/done handshake so the CPU control can stall while a multi-cycle operation is in flight.

---
 rtl/mips_muldiv_pkg.sv | 17 +
 rtl/mips_muldiv_unit_if.sv | 33 +++
 rtl/muldiv_step.sv | 37 +++
 rtl/mips_muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes and FSM states.
package mips_muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between CPU control and the multiply/divide unit.
interface mips_muldiv_unit_if
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
);

  // Handshake: start is a request that is only taken while busy==0; a request seen
  // while busy is dropped, so the requester holds start/op/rs_val/rt_val until busy
  // rises (MULT/MULTU/DIV/DIVU) or for one edge (MTHI/MTLO, which complete at that
  // edge). done is a single-cycle pulse; hi/lo/div_by_zero are valid in that cycle.
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  state_e          state_dbg;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, div_by_zero, hi, lo, state_dbg
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, div_by_zero, hi, lo, state_dbg
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: radix-2 shift-add (multiply)
// or restoring shift-subtract (divide) on a shared 2*XLEN accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifts right.
  // Divide:   acc = {remainder, dividend/quotient bits}, shifts left; quotient
  // bits enter at the bottom as dividend bits leave the top.
  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
    shifted = acc_i[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, opnd_i};
    acc_o   = acc_i;
    if (div_mode_i) begin
      if (!diff[XLEN]) begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else if (acc_i[0]) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      acc_o = {1'b0, acc_i[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, plus MTHI/MTLO.
// Works on operand magnitudes during CALC and applies signs once in FIX.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               CLK,
  input logic               RST,
  mips_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                div_q, div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                dbz_q, dbz_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;
  logic                dbz_out_q, dbz_out_d;

  logic                signed_op;
  logic                rs_neg;
  logic                rt_neg;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [2*XLEN-1:0]   step_acc;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo;
  logic [XLEN-1:0]     rem;
  logic [XLEN-1:0]     fix_hi;
  logic [XLEN-1:0]     fix_lo;

  // Even op codes among 000..011 are the signed variants.
  assign signed_op = ~bus.op[0];
  assign rs_neg    = signed_op & bus.rs_val[XLEN-1];
  assign rt_neg    = signed_op & bus.rt_val[XLEN-1];
  assign mag_a     = rs_neg ? -bus.rs_val : bus.rs_val;
  assign mag_b     = rt_neg ? -bus.rt_val : bus.rt_val;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_mode_i (div_q),
    .acc_i      (acc_q),
    .opnd_i     (opnd_q),
    .acc_o      (step_acc)
  );

  // A zero divisor leaves the dividend magnitude as remainder; re-signing it
  // with the dividend sign reproduces the original rs bit pattern for HI.
  assign prod   = neg_lo_q ? -acc_q : acc_q;
  assign quo    = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem    = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign fix_hi = div_q ? rem : prod[2*XLEN-1:XLEN];
  assign fix_lo = div_q ? (dbz_q ? '1 : quo) : prod[XLEN-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              div_d    = bus.op[1];
              acc_d    = {{XLEN{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
              opnd_d   = bus.op[1] ? mag_b : mag_a;
              neg_lo_d = rs_neg ^ rt_neg;
              neg_hi_d = rs_neg;
              dbz_d    = bus.op[1] & (bus.rt_val == '0);
              cnt_d    = '0;
              state_d  = CALC;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        hi_d      = fix_hi;
        lo_d      = fix_lo;
        done_d    = 1'b1;
        dbz_out_d = dbz_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      div_q     <= div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: arithmetic reference model plus literal results.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  localparam int XLEN = 32;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic [64:0] exp_q[$];

  mips_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  mips_muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {div_by_zero, hi, lo} from MIPS arithmetic rules.
  function automatic logic [64:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT: begin
        sp = sa * sb;
        return {1'b0, 64'(sp)};
      end
      OP_MULTU: begin
        up = ua * ub;
        return {1'b0, up};
      end
      OP_DIV: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {1'b0, r, q};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
      default: return 65'd0;
    endcase
  endfunction

  // ---------------- scoreboard compare ----------------
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge CLK);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("done_without_request", 64'(bus.done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          exp_hi = e[63:32];
          exp_lo = e[31:0];
          check("sb_div_by_zero", 64'(bus.div_by_zero), 64'(e[64]));
        end
      end else begin
        check("sb_dbz_outside_done", 64'(bus.div_by_zero), 64'd0);
      end
      check("sb_hi", 64'(bus.hi), 64'(exp_hi));
      check("sb_lo", 64'(bus.lo), 64'(exp_lo));
    end
  end

  // ---------------- driver tasks ----------------
  // Runs one iterative op; optionally pokes an MTHI while busy and pins literal results.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit back2back, input int poke_at, input bit has_lit,
                       input logic [31:0] lit_hi, input logic [31:0] lit_lo,
                       input bit lit_dbz);
    int n;
    int busy_n;
    bit got;
    if (!back2back) begin
      @(posedge CLK);
      #1;
    end
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge CLK);
    exp_q.push_back(model(op, a, b));
    #1;
    bus.start = 1'b0;
    n = 0;
    busy_n = bus.busy ? 1 : 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
      if (n == poke_at) begin
        bus.start  = 1'b1;
        bus.op     = OP_MTHI;
        bus.rs_val = 32'hDEAD_BEEF;
      end else if (n == poke_at + 1) begin
        bus.start = 1'b0;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    check("done_latency", 64'(n), 64'(XLEN + 1));
    check("busy_cycles", 64'(busy_n), 64'(XLEN + 1));
    if (has_lit) begin
      check("lit_hi", 64'(bus.hi), 64'(lit_hi));
      check("lit_lo", 64'(bus.lo), 64'(lit_lo));
      check("lit_dbz", 64'(bus.div_by_zero), 64'(lit_dbz));
    end
  endtask

  task automatic do_move(input logic [2:0] op, input logic [31:0] val);
    @(posedge CLK);
    #1;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = val;
    @(posedge CLK);
    if (op == OP_MTHI) exp_hi = val;
    if (op == OP_MTLO) exp_lo = val;
    #1;
    bus.start = 1'b0;
    check("move_busy", 64'(bus.busy), 64'd0);
    check("move_done", 64'(bus.done), 64'd0);
    check("move_value", 64'(op == OP_MTHI ? bus.hi : bus.lo), 64'(val));
    @(posedge CLK);
    #1;
    check("move_done_later", 64'(bus.done), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] bad_op;
    checks     = 0;
    errors     = 0;
    exp_hi     = '0;
    exp_lo     = '0;
    RST        = 1'b1;
    bus.start  = 1'b0;
    bus.op     = OP_MULT;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'(IDLE));
    RST = 1'b0;

    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,        0, -1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    do_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, -1, 1, 32'h0,         32'h1,         0);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,        0, -1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op(OP_DIVU,  32'd7,         32'd2,        0, -1, 1, 32'd1,         32'd3,         0);
    do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 0, -1, 1, 32'd1,         32'hFFFF_FFFD, 0);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 1, 32'd0,         32'h8000_0000, 0);
    do_op(OP_DIVU,  32'd5,         32'd0,        0, -1, 1, 32'd5,         32'hFFFF_FFFF, 1);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,        1, -1, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    do_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, -1, 0, 32'd0, 32'd0, 0);
    do_op(OP_DIV,   32'd100,       32'hFFFF_FFF9, 0, -1, 0, 32'd0, 32'd0, 0);
    do_op(OP_DIVU,  32'hFFFF_FFFF, 32'd3,        0, -1, 0, 32'd0, 32'd0, 0);
    do_op(OP_MULT,  32'd3,         32'd5,        0, 10, 1, 32'd0,         32'd15,        0);

    do_move(OP_MTLO, 32'h0000_1234);
    do_move(OP_MTHI, 32'hCAFE_F00D);

    bad_op = 3'b110;
    @(posedge CLK);
    #1;
    bus.start  = 1'b1;
    bus.op     = bad_op;
    bus.rs_val = 32'h5555_AAAA;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    check("bad_op_busy", 64'(bus.busy), 64'd0);
    @(posedge CLK);
    #1;
    check("bad_op_done", 64'(bus.done), 64'd0);

    // Asynchronous reset in the middle of a divide.
    @(posedge CLK);
    #1;
    bus.start  = 1'b1;
    bus.op     = OP_DIV;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    repeat (11) @(posedge CLK);
    #1;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #1;
    RST = 1'b1;
    exp_q.delete();
    exp_hi = '0;
    exp_lo = '0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hi", 64'(bus.hi), 64'd0);
    check("async_rst_lo", 64'(bus.lo), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    do_op(OP_MULTU, 32'd2, 32'd3, 0, -1, 1, 32'd0, 32'd6, 0);

    repeat (3) @(posedge CLK);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
